// File: rtl/modred_pkg.sv
// Shared types and helpers for the modular-reducer stream driver.
package modred_pkg;

   localparam int unsigned DATA_W_DEF = 64;
   localparam int unsigned MAX_W      = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Ceiling log2, matching $clog2 semantics (0 and 1 both map to 0).
   function automatic int unsigned clog2_w(input logic [MAX_W-1:0] v);
      logic [MAX_W-1:0] vm1;
      int unsigned      r;
      r   = 0;
      vm1 = v - MAX_W'(1);
      if (v > MAX_W'(1)) begin
         for (int i = 0; i < MAX_W; i++) begin
            if (vm1[i]) r = 32'(i) + 32'd1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/modred_stream_driver_if.sv
// Driver <-> pipelined reducer handshake bundle.
interface modred_stream_driver_if
   import modred_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
);
   logic              red_start;
   logic [DATA_W-1:0] red_x;
   logic [DATA_W-1:0] red_m;
   logic [DATA_W-1:0] red_m_bl;
   logic              red_valid;
   logic [DATA_W-1:0] red_result;

   modport master (
      output red_start, red_x, red_m, red_m_bl,
      input  red_valid, red_result
   );

   modport slave (
      input  red_start, red_x, red_m, red_m_bl,
      output red_valid, red_result
   );
endinterface

// File: rtl/modred_sbuf.sv
// 1W/1R buffer: synchronous write, asynchronous read.
module modred_sbuf #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 64,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/modred_stream_driver.sv
// Batch initiator for the pipelined modular reducer: load operands, stream, collect, read back.
// Optional watchdog: define MODRED_DRV_TIMEOUT_EN to enable the TIMEOUT parameter and counter.
module modred_stream_driver
   import modred_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned DEPTH   = 64
`ifdef MODRED_DRV_TIMEOUT_EN
   , parameter int unsigned TIMEOUT = 32
`endif
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clr_i,
   input  logic                   wr_en_i,
   input  logic [DATA_W-1:0]      wr_data_i,
   output logic                   wr_full_o,
   output logic [$clog2(DEPTH):0] count_o,
   input  logic [DATA_W-1:0]      m_i,
   input  logic                   go_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   modred_stream_driver_if.master red,
   input  logic                   rd_en_i,
   output logic [DATA_W-1:0]      rd_data_o,
   output logic                   rd_empty_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   state_e            state_q, state_d;
   logic [CW-1:0]     count_q, iss_q, rcv_q, rd_q;
   logic [DATA_W-1:0] m_q, m_bl_q;
   logic              err_q;
   logic [DATA_W-1:0] op_rdata, res_rdata;

   logic idle_c, issue_c, outst_c, accept_c, spurious_c;
   logic go_acc_c, clr_acc_c, wr_acc_c, rd_acc_c, last_issue_c, timeout_c;

   assign idle_c       = (state_q == IDLE);
   assign issue_c      = (state_q == ISSUE);
   assign outst_c      = (iss_q != rcv_q);
   assign accept_c     = red.red_valid && outst_c;
   assign spurious_c   = red.red_valid && !outst_c;
   assign go_acc_c     = idle_c && go_i;
   assign clr_acc_c    = idle_c && clr_i && !go_i;
   assign wr_acc_c     = idle_c && wr_en_i && !go_i && !clr_i && !wr_full_o;
   assign rd_acc_c     = idle_c && rd_en_i && !go_i && !clr_i && !rd_empty_o;
   assign last_issue_c = issue_c && ((iss_q + CW'(1)) == count_q);

`ifdef MODRED_DRV_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_q;
   logic            wd_run_c;

   assign wd_run_c  = (issue_c || (state_q == DRAIN)) && outst_c;
   assign timeout_c = wd_run_c && !accept_c && (wd_q == WD_W'(TIMEOUT - 1));

   // Watchdog restarts on every batch start and on every accepted result.
   always_ff @(posedge clk_i) begin
      if (rst_i || go_acc_c || accept_c) wd_q <= '0;
      else if (wd_run_c)                 wd_q <= wd_q + WD_W'(1);
   end
`else
   assign timeout_c = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (go_i) state_d = (count_q == '0) ? DONE : ISSUE;
         ISSUE:   if (timeout_c) state_d = DONE;
                  else if (last_issue_c) state_d = DRAIN;
         DRAIN:   if (timeout_c || (rcv_q == count_q)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o        = 1'b0;
      done_o        = 1'b0;
      red.red_start = 1'b0;
      unique case (state_q)
         IDLE:    ;
         ISSUE:   begin busy_o = 1'b1; red.red_start = 1'b1; end
         DRAIN:   busy_o = 1'b1;
         DONE:    begin busy_o = 1'b1; done_o = 1'b1; end
         default: ;
      endcase
   end

   // Counters, latched modulus and sticky error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         iss_q   <= '0;
         rcv_q   <= '0;
         rd_q    <= '0;
         m_q     <= '0;
         m_bl_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         if (go_acc_c) begin
            m_q    <= m_i;
            m_bl_q <= DATA_W'(clog2_w(MAX_W'(m_i)));
            iss_q  <= '0;
            rcv_q  <= '0;
            rd_q   <= '0;
         end else begin
            if (clr_acc_c) begin
               count_q <= '0;
               iss_q   <= '0;
               rcv_q   <= '0;
               rd_q    <= '0;
            end
            if (wr_acc_c) count_q <= count_q + CW'(1);
            if (issue_c)  iss_q   <= iss_q + CW'(1);
            if (accept_c) rcv_q   <= rcv_q + CW'(1);
            if (rd_acc_c) rd_q    <= rd_q + CW'(1);
         end
         if (spurious_c || timeout_c) err_q <= 1'b1;
         else if (clr_acc_c)          err_q <= 1'b0;
      end
   end

   modred_sbuf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_op_buf (
      .clk_i (clk_i),
      .we    (wr_acc_c),
      .waddr (count_q[AW-1:0]),
      .wdata (wr_data_i),
      .raddr (iss_q[AW-1:0]),
      .rdata (op_rdata)
   );

   modred_sbuf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_res_buf (
      .clk_i (clk_i),
      .we    (accept_c),
      .waddr (rcv_q[AW-1:0]),
      .wdata (red.red_result),
      .raddr (rd_q[AW-1:0]),
      .rdata (res_rdata)
   );

   assign red.red_x    = issue_c ? op_rdata : '0;
   assign red.red_m    = m_q;
   assign red.red_m_bl = m_bl_q;
   assign wr_full_o    = (count_q == CW'(DEPTH));
   assign count_o      = count_q;
   assign err_o        = err_q;
   assign rd_empty_o   = (rd_q == rcv_q);
   assign rd_data_o    = rd_empty_o ? '0 : res_rdata;
endmodule
